// File: rtl/tff_bank_rr_sched.sv
// tff_bank_rr_sched: round-robin scheduler that applies one requester's toggle mask per cycle to a shared T-cell bank.
module tff_bank_rr_sched #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int CNTW = 16,
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic                  gnt_vld,
  output logic [WIDTH-1:0]      q,
  output logic [CNTW-1:0]       toggle_cnt
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [WIDTH-1:0] sel;
  logic [NREQ-1:0] elig;
  logic hit;
  logic fire;
  // last cycle's grantee is masked out so a still-high req cannot be re-granted
  assign elig = req & ~gnt;
  assign fire = en && hit;
  always_comb begin
    hit = 1'b0;
    win = '0;
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        win = IDW'(idx);
        sel = mask[idx*WIDTH +: WIDTH];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= '0;
      gnt_id <= '0;
      gnt_vld <= 1'b0;
      q <= '0;
      toggle_cnt <= '0;
      ptr <= '0;
    end else begin
      gnt <= fire ? NREQ'(1) << win : '0;
      gnt_vld <= fire;
      gnt_id <= fire ? win : gnt_id;
      ptr <= !fire ? ptr : win == IDW'(NREQ-1) ? '0 : win + IDW'(1);
      toggle_cnt <= fire && !(&toggle_cnt) ? toggle_cnt + CNTW'(1) : toggle_cnt;
      q <= clr ? '0 : fire ? q ^ sel : q;
    end
  end
endmodule

// File: tb/tb_tff_bank_rr_sched.sv
// tb_tff_bank_rr_sched: directed self-checking bench for the round-robin T-cell bank scheduler.
module tb_tff_bank_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic clr = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] mask = '0;
  logic [3:0] gnt, gnt4;
  logic [1:0] gnt_id, gnt_id4;
  logic gnt_vld, gnt_vld4;
  logic [7:0] q, q4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  int checks = 0;
  int errors = 0;

  tff_bank_rr_sched #(.NREQ(4), .WIDTH(8), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .mask(mask),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .q(q), .toggle_cnt(cnt)
  );
  tff_bank_rr_sched #(.NREQ(4), .WIDTH(8), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req), .mask(mask),
    .gnt(gnt4), .gnt_id(gnt_id4), .gnt_vld(gnt_vld4), .q(q4), .toggle_cnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b/%b exp=0000/0", gnt, gnt_vld); end
    checks++; if (gnt_id !== 2'd0 || cnt !== 16'd0) begin errors++; $display("FAIL reset_id_cnt got=%0d/%0d exp=0/0", gnt_id, cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    mask[7:0] = 8'hA5;
    req = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin errors++; $display("FAIL single_gnt got=%b/%0d/%b exp=0001/0/1", gnt, gnt_id, gnt_vld); end
    checks++; if (q !== 8'hA5 || cnt !== 16'd1) begin errors++; $display("FAIL single_q got=%h/%0d exp=a5/1", q, cnt); end
    step();
    checks++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || q !== 8'hA5) begin errors++; $display("FAIL single_excl got=%b/%b/%0d/%h exp=0000/0/0/a5", gnt, gnt_vld, gnt_id, q); end
    step();
    checks++; if (gnt !== 4'b0001 || q !== 8'h00 || cnt !== 16'd2) begin errors++; $display("FAIL single_repeat got=%b/%h/%0d exp=0001/00/2", gnt, q, cnt); end
    req = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] qs [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    rst = 1'b1;
    step();
    rst = 1'b0;
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (gnt_id !== ids[i] || q !== qs[i] || gnt_vld !== 1'b1) begin errors++; $display("FAIL rr_%0d got=%0d/%h/%b exp=%0d/%h/1", i, gnt_id, q, gnt_vld, ids[i], qs[i]); end
    end
    req = '0;
    step();
    checks++; if (gnt !== 4'b0000 || cnt !== 16'd5) begin errors++; $display("FAIL rr_idle got=%b/%0d exp=0000/5", gnt, cnt); end
  endtask

  task automatic test_contention();
    req = 4'b0010;
    step();
    req = '0;
    step();
    req = 4'b0011;
    step();
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL cont_ptr2_first got=%0d exp=0", gnt_id); end
    step();
    checks++; if (gnt_id !== 2'd1 || q !== 8'h0F) begin errors++; $display("FAIL cont_ptr2_second got=%0d/%h exp=1/0f", gnt_id, q); end
    req = 4'b0001;
    step();
    req = '0;
    step();
    req = 4'b1001;
    step();
    checks++; if (gnt_id !== 2'd3 || q !== 8'h06) begin errors++; $display("FAIL cont_ptr1_first got=%0d/%h exp=3/06", gnt_id, q); end
    step();
    checks++; if (gnt_id !== 2'd0 || q !== 8'h07 || cnt !== 16'd11) begin errors++; $display("FAIL cont_ptr1_second got=%0d/%h/%0d exp=0/07/11", gnt_id, q, cnt); end
    req = '0;
    step();
  endtask

  task automatic test_en_gating();
    en = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (gnt !== 4'b0000 || q !== 8'h07 || cnt !== 16'd11) begin errors++; $display("FAIL en_hold_%0d got=%b/%h/%0d exp=0000/07/11", i, gnt, q, cnt); end
    end
    en = 1'b1;
    step();
    checks++; if (gnt !== 4'b0100 || gnt_id !== 2'd2 || q !== 8'h03 || cnt !== 16'd12) begin errors++; $display("FAIL en_release got=%b/%0d/%h/%0d exp=0100/2/03/12", gnt, gnt_id, q, cnt); end
    req = '0;
    step();
  endtask

  task automatic test_clr();
    clr = 1'b1;
    step();
    checks++; if (q !== 8'h00 || gnt !== 4'b0000 || cnt !== 16'd12) begin errors++; $display("FAIL clr_only got=%h/%b/%0d exp=00/0000/12", q, gnt, cnt); end
    clr = 1'b0;
    mask[15:8] = 8'h3C;
    req = 4'b0010;
    step();
    checks++; if (q !== 8'h3C || gnt_id !== 2'd1) begin errors++; $display("FAIL clr_setup got=%h/%0d exp=3c/1", q, gnt_id); end
    req = '0;
    step();
    mask[15:8] = 8'hFF;
    req = 4'b0010;
    clr = 1'b1;
    step();
    checks++; if (q !== 8'h00 || gnt !== 4'b0010 || cnt !== 16'd14) begin errors++; $display("FAIL clr_vs_grant got=%h/%b/%0d exp=00/0010/14", q, gnt, cnt); end
    clr = 1'b0;
    req = '0;
    step();
  endtask

  task automatic test_reset_saturation();
    mask = {8'h08, 8'h04, 8'h02, 8'h01};
    req = 4'b0110;
    rst = 1'b1;
    step();
    checks++; if (q !== 8'h00 || gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || cnt !== 16'd0) begin errors++; $display("FAIL midrst got=%h/%b/%b/%0d/%0d exp=00/0000/0/0/0", q, gnt, gnt_vld, gnt_id, cnt); end
    rst = 1'b0;
    step();
    checks++; if (gnt !== 4'b0010 || gnt_id !== 2'd1 || q !== 8'h02) begin errors++; $display("FAIL midrst_first got=%b/%0d/%h exp=0010/1/02", gnt, gnt_id, q); end
    req = 4'b1111;
    for (int i = 0; i < 20; i++) step();
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt4); end
    checks++; if (cnt !== 16'd21) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=21", cnt); end
    req = '0;
    step();
    checks++; if (cnt4 !== 4'd15 || gnt4 !== 4'b0000) begin errors++; $display("FAIL sat_hold got=%0d/%b exp=15/0000", cnt4, gnt4); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_en_gating();
    test_clr();
    test_reset_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tff_bank_rr_sched.md
Name: tff_bank_rr_sched

Overview:
- Shared bank of WIDTH toggle (T) cells whose state is flipped on behalf of NREQ requesters.
- Each requester presents a toggle mask.
- A round-robin scheduler grants at most one requester per cycle; the granted mask is XORed into the bank.
- Sits between the daily-exercise stimulus agents and the T-cell storage. It serialises toggle traffic so that no two masks are applied in the same cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of T cells in the bank.
- CNTW, 16, width of the applied-toggle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  global enable; when low, no grants are issued and the bank holds.
- clr  input  1  synchronous bank clear; bank goes to all-zero, pointer and counter unaffected.
- req  input  NREQ  per-requester request, level, held until granted.
- mask  input  NREQ*WIDTH  requester i mask at bits [i*WIDTH +: WIDTH]; 1 = toggle that cell.
- gnt  output  NREQ  one-hot registered grant, one-cycle pulse.
- gnt_id  output  clog2(NREQ) (min 1)  index of the current grant; valid when gnt_vld=1.
- gnt_vld  output  1  high in any cycle where gnt is non-zero.
- q  output  WIDTH  bank state.
- toggle_cnt  output  CNTW  number of grants applied since reset, saturating.

Behaviour:
- Reset, at a clk edge with rst=1: q=0, gnt=0, gnt_id=0, gnt_vld=0, toggle_cnt=0, round-robin pointer ptr=0. rst has priority over everything else.
- Eligibility: eligible[i] = req[i] AND NOT gnt[i]. The requester granted last cycle is excluded, so a req still high in the cycle gnt is visible cannot be re-granted.
- Arbitration, combinational: search eligible from index ptr upward, wrapping modulo NREQ. The first hit is the winner.
- Each edge with rst=0, en=1 and a winner w exists:
  - gnt <= one-hot(w), gnt_id <= w, gnt_vld <= 1.
  - q <= q XOR mask[w], or 0 if clr=1 (clr wins, mask discarded, grant still consumed).
  - ptr <= (w+1) mod NREQ.
  - toggle_cnt <= toggle_cnt+1, saturating at all-ones.
- Each edge with en=0 or no winner:
  - gnt <= 0, gnt_vld <= 0, gnt_id holds.
  - q <= 0 if clr=1, else q holds.
  - ptr and toggle_cnt hold.
- Latency: req rising before edge N → gnt and updated q visible after edge N. This is one cycle, with no contention and en=1.
- Requester protocol:
  - Drop req, or present a new mask, in the cycle after gnt is seen.
  - A req kept high across two cycles after gnt is treated as a new request; it becomes eligible again one cycle later.
- Mask is sampled only at the grant edge; changes while waiting are legal and the latest value is used.
- A mask of all-zero is a legal grant: counted, q unchanged.
- Fairness: with all NREQ requesting continuously (re-asserting), grants rotate and each requester is served at least once every NREQ+1 cycles.
- Wrap: ptr from NREQ-1 returns to 0.
- toggle_cnt saturates, it does not wrap.
- rst asserted mid-stream: pending requests are ignored that edge. After release, arbitration restarts from ptr=0.
- en deasserted: scheduler freezes; pending reqs remain pending, no grant is lost or duplicated.

Test Plan:
- Reset then single request: rst 2 cycles; req=0001, mask0=0xA5 → next edge gnt=0001, gnt_id=0, q=0xA5, toggle_cnt=1. Repeat the request with the same mask → q=0x00, toggle_cnt=2.
- Round robin: req=1111 held (re-asserting), masks 0x01,0x02,0x04,0x08, en=1 → grant order 0,1,2,3 on alternating/available cycles, q=0x0F after all four, ptr wraps to 0.
- Contention after pointer advance: ptr=2, req=0011 → gnt_id=0 then 1; req=1001 with ptr=1 → gnt_id=3 first.
- en gating: req=0100, en=0 for 5 cycles → gnt=0, q unchanged, toggle_cnt unchanged; en=1 → grant on next edge.
- clr versus grant same edge: q=0x3C, req=0010, mask1=0xFF, clr=1 → q=0x00, gnt=0010, toggle_cnt incremented.
- Reset mid-operation and saturation: CNTW=4, 20 grants → toggle_cnt=15. rst pulse during active req → all outputs 0, ptr=0, first post-reset grant goes to the lowest requesting index.
